uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Frame-sequencing controller for the UART receiver. It detects the start condition, runs the per-bit edge and bit counters, and enables the sampler, start checker, deserializer, parity checker and stop checker in turn. It collects their error flags and issues a one-cycle data_valid, or error pulses, at the end of each frame.

Parameters:
PRESCALE_WIDTH, 6, width of prescale input
DATA_WIDTH, 8, data bits per frame
BIT_CNT_WIDTH, 4, width of bit_cnt; must hold DATA_WIDTH+2

Ports:
CLK  input  1  oversampling clock
RST  input  1  reset
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  frame carries a parity bit
prescale  input  PRESCALE_WIDTH  oversampling ratio: 8, 16 or 32
strt_glitch  input  1  start checker: start bit sampled high
par_err  input  1  parity checker flag
stp_err  input  1  stop checker flag
edge_cnt  output  5  oversample edge index within current bit
bit_cnt  output  BIT_CNT_WIDTH  bit index within frame (start=0)
data_samp_en  output  1  enable majority sampler
strt_chk_en  output  1  enable start checker
deser_en  output  1  enable deserializer
par_chk_en  output  1  enable parity checker
stp_chk_en  output  1  enable stop checker
data_valid  output  1  one-cycle pulse: frame good, deserializer data valid
parity_error  output  1  one-cycle pulse at frame end
framing_error  output  1  one-cycle pulse at frame end
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: RST, asynchronous, active-low; clock CLK. Reset forces state IDLE, edge_cnt=0, bit_cnt=0, all enables 0, data_valid/parity_error/framing_error 0, and clears the latched prescale and parity-sticky registers. Reset mid-frame abandons the frame with no pulse.
- Latched ratio P: prescale is captured on the IDLE->START transition. Values other than 8/16/32 map to 8. Changes to prescale mid-frame are ignored.
- Counters: active in every state except IDLE. edge_cnt counts 0..P-1; at P-1 it wraps to 0 and bit_cnt increments. "Bit end" means edge_cnt==P-1. Counters are held at 0 in IDLE.
- States (Moore enables decoded from state):
  - IDLE: all enables 0. If RX_IN==0 at a CLK edge, go to START next, with edge_cnt=0, bit_cnt=0.
  - START: data_samp_en=1, strt_chk_en=1. At bit end: if strt_glitch=1, go to IDLE with no pulses and clear the counters. Otherwise go to DATA.
  - DATA: data_samp_en=1, deser_en=1. At bit end with bit_cnt==DATA_WIDTH: go to PARITY if PAR_EN=1, else STOP. PAR_EN is sampled at that edge.
  - PARITY: data_samp_en=1, par_chk_en=1. At bit end, latch par_err into par_sticky and go to STOP.
  - STOP: data_samp_en=1, stp_chk_en=1. At bit end, go to IDLE and generate the end-of-frame pulses:
    - data_valid = !stp_err & !par_sticky
    - framing_error = stp_err
    - parity_error = par_sticky
    - par_sticky is cleared.
- Checker flags are registered one cycle after their sample edge, and that sample edge is ≤ P/2+2 < P-1. Flags are therefore stable at bit end.
- Output pulses are registered: high for exactly one cycle, the cycle after the STOP bit-end edge.
- Frame length: with L = 10 bits (no parity) or 11 (parity), START is entered at edge N. The last STOP bit-end occurs in the cycle following edge N+L*P-1, and the pulses are visible after edge N+L*P.
- Back-to-back frames: the next start bit is detected in IDLE one cycle after the previous frame ends. One cycle of skew is accepted.
- RX_IN is ignored outside IDLE; the FSM never aborts on line activity.

Decomposition:
- Shared package uart_rx_pkg: state encoding (IDLE, START, DATA, PARITY, STOP as 3-bit localparams) and supported prescale constants 8/16/32.
- Sub-module edge_bit_counter: enable in; P in; edge_cnt/bit_cnt out; bit_end strobe out.
- FSM and pulse registers live in uart_rx_ctrl.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 with good stop, START entered at edge N -> data_valid=1 for one cycle after edge N+80; no error pulses; busy low afterwards.
- P=16, PAR_EN=1, par_err forced 1 during the parity bit, good stop -> parity_error pulse after edge N+176; data_valid stays 0.
- P=8, stp_err=1 at stop-bit end -> framing_error pulse; data_valid 0; FSM back in IDLE.
- P=8, strt_glitch=1 at START bit end (edge N+7) -> IDLE at N+8, counters 0, no pulses.
- prescale changed from 8 to 32 mid-frame -> frame still completes in 80 cycles at P=8.
- RST asserted in the DATA state at bit_cnt=4 -> all outputs 0 immediately (asynchronous); no pulse after release; the next frame is received normally.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state encoding and supported oversampling ratios for the UART receiver
package uart_rx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic [5:0] P8  = 6'd8;
  localparam logic [5:0] P16 = 6'd16;
  localparam logic [5:0] P32 = 6'd32;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: line, checker-flag and enable/pulse signals between the frame controller and the receiver datapath
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      strt_glitch;
  logic                      par_err;
  logic                      stp_err;
  logic [4:0]                edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      data_samp_en;
  logic                      strt_chk_en;
  logic                      deser_en;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic                      data_valid;
  logic                      parity_error;
  logic                      framing_error;
  logic                      busy;
  modport master (
    input  RX_IN, PAR_EN, prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en, par_chk_en,
           stp_chk_en, data_valid, parity_error, framing_error, busy
  );
  modport slave (
    output RX_IN, PAR_EN, prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en, par_chk_en,
           stp_chk_en, data_valid, parity_error, framing_error, busy
  );
endinterface

// File: rtl/edge_bit_counter.sv
// edge_bit_counter: oversample edge counter wrapping at P-1 and frame bit counter, with a bit-end strobe
module edge_bit_counter #(
  parameter int BIT_CNT_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_active,
  input  logic                     i_clr,
  input  logic [5:0]               i_p,
  output logic [4:0]               o_edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0] o_bit_cnt,
  output logic                     o_bit_end
);
  logic [4:0]               r_edge_cnt;
  logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_bit_end  = i_active && ({1'b0, r_edge_cnt} == i_p - 6'd1);
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (!i_active || i_clr) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (o_bit_end) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 1'b1;
    end else begin
      r_edge_cnt <= r_edge_cnt + 5'd1;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer; enables the datapath checkers bit by bit and pulses the frame result
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_ctrl_if.master bus
);
  state_t                   r_state, w_next;
  logic [5:0]               r_p, w_p;
  logic                     r_par_sticky, r_data_valid, r_parity_error, r_framing_error;
  logic                     w_bit_end, w_stop_end;
  logic [4:0]               w_edge_cnt;
  logic [BIT_CNT_WIDTH-1:0] w_bit_cnt;
  assign w_p = (bus.prescale == PRESCALE_WIDTH'(P16)) ? P16 :
               (bus.prescale == PRESCALE_WIDTH'(P32)) ? P32 : P8;
  // clearing on the transition into IDLE lets the counters read 0 in the first IDLE cycle
  edge_bit_counter #(.BIT_CNT_WIDTH(BIT_CNT_WIDTH)) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_active   (r_state != IDLE),
    .i_clr      (w_next == IDLE),
    .i_p        (r_p),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_bit_end  (w_bit_end)
  );
  assign w_stop_end = (r_state == STOP) && w_bit_end;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.RX_IN ? IDLE : START;
      START:   w_next = !w_bit_end ? START : bus.strt_glitch ? IDLE : DATA;
      DATA:    w_next = !(w_bit_end && w_bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH)) ? DATA :
                        bus.PAR_EN ? PARITY : STOP;
      PARITY:  w_next = w_bit_end ? STOP : PARITY;
      STOP:    w_next = w_bit_end ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  assign bus.edge_cnt      = w_edge_cnt;
  assign bus.bit_cnt       = w_bit_cnt;
  assign bus.busy          = r_state != IDLE;
  assign bus.data_samp_en  = r_state != IDLE;
  assign bus.strt_chk_en   = r_state == START;
  assign bus.deser_en      = r_state == DATA;
  assign bus.par_chk_en    = r_state == PARITY;
  assign bus.stp_chk_en    = r_state == STOP;
  assign bus.data_valid    = r_data_valid;
  assign bus.parity_error  = r_parity_error;
  assign bus.framing_error = r_framing_error;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state         <= IDLE;
      r_p             <= '0;
      r_par_sticky    <= 1'b0;
      r_data_valid    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_p             <= (r_state == IDLE && w_next == START) ? w_p : r_p;
      r_par_sticky    <= (r_state == PARITY && w_bit_end) ? bus.par_err :
                         w_stop_end ? 1'b0 : r_par_sticky;
      r_data_valid    <= w_stop_end && !bus.stp_err && !r_par_sticky;
      r_parity_error  <= w_stop_end && r_par_sticky;
      r_framing_error <= w_stop_end && bus.stp_err;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame scenarios for uart_rx_ctrl with hand-computed enables, counters and end-of-frame pulses
module tb_uart_rx_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [8:0] flags;
  uart_rx_ctrl_if #(.PRESCALE_WIDTH(6), .BIT_CNT_WIDTH(4)) bus ();
  uart_rx_ctrl #(.PRESCALE_WIDTH(6), .DATA_WIDTH(8), .BIT_CNT_WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );
  always #5 CLK = ~CLK;
  // busy, samp, strt, deser, par, stp, data_valid, parity_error, framing_error
  assign flags = {bus.busy, bus.data_samp_en, bus.strt_chk_en, bus.deser_en, bus.par_chk_en,
                  bus.stp_chk_en, bus.data_valid, bus.parity_error, bus.framing_error};
  localparam logic [8:0] F_IDLE = 9'b0_0000_0000;
  localparam logic [8:0] F_STRT = 9'b1_1100_0000;
  localparam logic [8:0] F_DATA = 9'b1_1010_0000;
  localparam logic [8:0] F_PAR  = 9'b1_1001_0000;
  localparam logic [8:0] F_STOP = 9'b1_1000_1000;
  localparam logic [8:0] F_DV   = 9'b0_0000_0100;
  localparam logic [8:0] F_PE   = 9'b0_0000_0010;
  localparam logic [8:0] F_FE   = 9'b0_0000_0001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic state(input string tag, input logic [8:0] f, input int e, input int b);
    chk({tag, "_flags"}, {23'd0, flags}, {23'd0, f});
    chk({tag, "_edge"}, {27'd0, bus.edge_cnt}, e);
    chk({tag, "_bit"}, {28'd0, bus.bit_cnt}, b);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk(tag, {23'd0, flags}, {23'd0, F_IDLE});
    end
  endtask

  task automatic start_frame;
    bus.RX_IN = 1'b0;
    step(1);
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    bus.RX_IN = 1'b1;
    bus.PAR_EN = 1'b0;
    bus.prescale = 6'd8;
    bus.strt_glitch = 1'b0;
    bus.par_err = 1'b0;
    bus.stp_err = 1'b0;
    step(1);
    state("reset", F_IDLE, 0, 0);
    bus.RX_IN = 1'b0;
    step(2);
    state("reset_hold", F_IDLE, 0, 0);
    bus.RX_IN = 1'b1;
    #3 RST = 1'b1;
    step(1);
    state("idle", F_IDLE, 0, 0);

    start_frame;
    state("t1_start", F_STRT, 0, 0);
    step(7);
    state("t1_start_end", F_STRT, 7, 0);
    step(1);
    state("t1_data1", F_DATA, 0, 1);
    step(71);
    state("t1_stop_end", F_STOP, 7, 9);
    step(1);
    state("t1_dv", F_DV, 0, 0);
    step(1);
    state("t1_after", F_IDLE, 0, 0);

    bus.prescale = 6'd16;
    bus.PAR_EN = 1'b1;
    start_frame;
    step(143);
    state("t2_data8_end", F_DATA, 15, 8);
    bus.par_err = 1'b1;
    step(1);
    state("t2_par", F_PAR, 0, 9);
    step(15);
    state("t2_par_end", F_PAR, 15, 9);
    step(1);
    bus.par_err = 1'b0;
    state("t2_stop", F_STOP, 0, 10);
    step(15);
    state("t2_stop_end", F_STOP, 15, 10);
    step(1);
    state("t2_pe", F_PE, 0, 0);
    step(1);
    state("t2_after", F_IDLE, 0, 0);
    bus.PAR_EN = 1'b0;
    bus.prescale = 6'd8;

    start_frame;
    step(72);
    state("t3_stop", F_STOP, 0, 9);
    bus.stp_err = 1'b1;
    step(8);
    state("t3_fe", F_FE, 0, 0);
    bus.stp_err = 1'b0;
    step(1);
    state("t3_after", F_IDLE, 0, 0);

    start_frame;
    step(6);
    bus.strt_glitch = 1'b1;
    step(1);
    state("t4_start_end", F_STRT, 7, 0);
    step(1);
    state("t4_abort", F_IDLE, 0, 0);
    bus.strt_glitch = 1'b0;
    quiet("t4_quiet", 12);

    start_frame;
    bus.prescale = 6'd32;
    step(79);
    state("t5_stop_end", F_STOP, 7, 9);
    step(1);
    state("t5_dv", F_DV, 0, 0);

    bus.prescale = 6'd5;
    start_frame;
    bus.prescale = 6'd8;
    step(79);
    state("t5b_stop_end", F_STOP, 7, 9);
    step(1);
    state("t5b_dv", F_DV, 0, 0);

    bus.prescale = 6'd32;
    start_frame;
    step(319);
    state("t5c_stop_end", F_STOP, 31, 9);
    step(1);
    state("t5c_dv", F_DV, 0, 0);
    bus.prescale = 6'd8;

    start_frame;
    step(34);
    state("t6_data4", F_DATA, 2, 4);
    #2 RST = 1'b0;
    #1;
    state("t6_async", F_IDLE, 0, 0);
    step(2);
    state("t6_held", F_IDLE, 0, 0);
    #2 RST = 1'b1;
    quiet("t6_quiet", 90);
    start_frame;
    step(79);
    state("t6_stop_end", F_STOP, 7, 9);
    step(1);
    state("t6_dv", F_DV, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
